// File: rtl/mem_port_sched.sv
// Shared main-memory command port scheduler: round-robin between instruction fetch
// and load/store, with fence.i drain/flush sequencing and one-cycle read return routing.
module mem_port_sched #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_wen,
  input  logic [3:0]    i_ls_ben,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
  input  logic          i_fence_req,
  output logic          o_fence_done,
  output logic          o_mem_ren,
  output logic          o_mem_wen,
  output logic [3:0]    o_mem_ben,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_fence_i,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ready
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    FENCE_DRAIN = 2'd2,
    FENCE_WAIT  = 2'd3
  } state_t;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_LS = 1'b1;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   owner_q, owner_d;
  logic   rd_out_q, rd_out_d;
  logic   tag_q, tag_d;

  logic   cmd_vld;
  logic   sel;

  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    owner_d       = owner_q;
    rd_out_d      = 1'b0;
    tag_d         = tag_q;
    cmd_vld       = 1'b0;
    sel           = SRC_IF;
    o_if_gnt      = 1'b0;
    o_ls_gnt      = 1'b0;
    o_fence_done  = 1'b0;
    o_mem_ren     = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_ben     = '0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_mem_fence_i = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_fence_req) begin
          state_d = FENCE_DRAIN;
        end else if (i_if_req || i_ls_req) begin
          cmd_vld = 1'b1;
          // On a tie the requester not granted last wins.
          sel = (i_if_req && i_ls_req) ? ~last_gnt_q : i_ls_req;
        end
      end
      ISSUE: begin
        // Locked: keep the stalled command on the port even if a fence arrives.
        sel     = owner_q;
        cmd_vld = owner_q ? i_ls_req : i_if_req;
        if (!cmd_vld) begin
          state_d = i_fence_req ? FENCE_DRAIN : IDLE;
        end
      end
      FENCE_DRAIN: begin
        // No grants happen here, so any in-flight read returns during this cycle.
        state_d = FENCE_WAIT;
      end
      FENCE_WAIT: begin
        o_mem_fence_i = 1'b1;
        if (i_mem_ready) begin
          o_fence_done = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cmd_vld) begin
      if (sel == SRC_LS) begin
        o_mem_ren   = ~i_ls_wen;
        o_mem_wen   = i_ls_wen;
        o_mem_ben   = i_ls_ben;
        o_mem_addr  = i_ls_addr;
        o_mem_wdata = i_ls_wdata;
      end else begin
        o_mem_ren   = 1'b1;
        o_mem_ben   = 4'hF;
        o_mem_addr  = i_if_addr;
      end
      if (i_mem_ready) begin
        o_if_gnt   = (sel == SRC_IF);
        o_ls_gnt   = (sel == SRC_LS);
        last_gnt_d = sel;
        rd_out_d   = o_mem_ren;
        tag_d      = sel;
        state_d    = i_fence_req ? FENCE_DRAIN : IDLE;
      end else begin
        owner_d = sel;
        state_d = ISSUE;
      end
    end

    // Reset forces every output quiet, including the combinational command path.
    if (i_rst) begin
      o_if_gnt      = 1'b0;
      o_ls_gnt      = 1'b0;
      o_fence_done  = 1'b0;
      o_mem_ren     = 1'b0;
      o_mem_wen     = 1'b0;
      o_mem_ben     = '0;
      o_mem_addr    = '0;
      o_mem_wdata   = '0;
      o_mem_fence_i = 1'b0;
    end
  end

  always_comb begin
    o_if_rvalid = 1'b0;
    o_ls_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_ls_rdata  = '0;
    if (!i_rst && rd_out_q) begin
      if (tag_q == SRC_LS) begin
        o_ls_rvalid = 1'b1;
        o_ls_rdata  = i_mem_rdata;
      end else begin
        o_if_rvalid = 1'b1;
        o_if_rdata  = i_mem_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= SRC_LS;
      owner_q    <= SRC_IF;
      rd_out_q   <= 1'b0;
      tag_q      <= SRC_IF;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      rd_out_q   <= rd_out_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: directed scenarios push expected events,
// a negedge monitor pops and checks grants, read returns and fence completions.
module tb_mem_port_sched;

  localparam int AW = 14;
  localparam int DW = 32;

  localparam int K_IFG  = 0;
  localparam int K_LSG  = 1;
  localparam int K_IFR  = 2;
  localparam int K_LSR  = 3;
  localparam int K_DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0, ls_wen = 1'b0;
  logic [3:0]    ls_ben = '0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          fence_req = 1'b0;
  logic          fence_done;
  logic          mem_ren, mem_wen, mem_fence_i;
  logic [3:0]    mem_ben;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 32'hDEADBEEF;
  logic          mem_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int            kind;
    int            cyc;
    logic [AW-1:0] addr;
    logic          wen;
    logic [3:0]    ben;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_port_sched #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_wen(ls_wen), .i_ls_ben(ls_ben),
    .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .i_fence_req(fence_req), .o_fence_done(fence_done),
    .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_ben(mem_ben),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_fence_i(mem_fence_i),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE0000 | {18'd0, a};
  endfunction

  // Memory model: accepted reads return a word the cycle after acceptance.
  always @(posedge clk) begin
    if (mem_ren && mem_ready) mem_rdata <= pat(mem_addr);
    else                      mem_rdata <= 32'hDEADBEEF;
  end

  task automatic push(input int kind, input int c, input logic [AW-1:0] addr,
                      input logic wen, input logic [3:0] ben,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = addr; e.wen = wen;
    e.ben = ben; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic check_event(input int k);
    int   idx;
    exp_t e;
    logic good;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].kind == k) idx = i;
    end
    tests++;
    if (idx < 0) begin
      fails++;
      $display("[TB] FAIL unexpected_event kind=%0d at cycle %0d: got event expected none", k, cyc);
      return;
    end
    e = sb[idx];
    sb.delete(idx);
    good = (e.cyc == cyc);
    case (k)
      K_IFG, K_LSG:
        good = good && (mem_ren == !e.wen) && (mem_wen == e.wen) && (mem_addr == e.addr)
               && (mem_ben == e.ben) && (mem_wdata == e.wdata) && !mem_fence_i;
      K_IFR: good = good && (if_rdata == e.rdata) && (ls_rvalid || ls_rdata == '0);
      K_LSR: good = good && (ls_rdata == e.rdata) && (if_rvalid || if_rdata == '0);
      default: ;
    endcase
    if (!good) begin
      fails++;
      $display("[TB] FAIL event kind=%0d: got cyc=%0d ren=%b wen=%b addr=%0h ben=%h wdata=%0h if_rd=%0h ls_rd=%0h expected cyc=%0d wen=%b addr=%0h ben=%h wdata=%0h rdata=%0h",
               k, cyc, mem_ren, mem_wen, mem_addr, mem_ben, mem_wdata, if_rdata, ls_rdata,
               e.cyc, e.wen, e.addr, e.ben, e.wdata, e.rdata);
    end else begin
      $display("[TB] ok   event kind=%0d at cycle %0d", k, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] ev;
    ev = {fence_done, ls_rvalid, if_rvalid, ls_gnt, if_gnt};
    for (int k = 0; k < 5; k++) begin
      if (ev[k]) check_event(k);
    end
    if (mem_ren && mem_wen) begin
      tests++;
      fails++;
      $display("[TB] FAIL ren_wen_exclusive: got ren=1 wen=1 expected at most one (cycle %0d)", cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return {6'd0, if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, fence_done,
            mem_ren, mem_wen, mem_ben, mem_addr, mem_wdata, mem_fence_i};
  endfunction

  function automatic logic [127:0] mem_cmd();
    return {75'd0, mem_ren, mem_wen, mem_fence_i, mem_ben, mem_addr, mem_wdata};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; fence_req = 1'b0; mem_ready = 1'b0;
    ls_wen = 1'b0; ls_ben = '0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
    step();
    @(negedge clk) chk("reset_outputs", all_outs(), '0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    int c;
    logic [127:0] wr_exp;

    // Round robin with both requesters pending: IF first after reset.
    do_reset();
    c = cyc;
    if_req = 1'b1; if_addr = 14'h0020;
    ls_req = 1'b1; ls_addr = 14'h0030; ls_wen = 1'b0; ls_ben = 4'hF; ls_wdata = '0;
    mem_ready = 1'b1;
    push(K_IFG, c,     14'h0020, 1'b0, 4'hF, '0, '0);
    push(K_IFR, c + 1, '0, 1'b0, 4'h0, '0, pat(14'h0020));
    push(K_LSG, c + 1, 14'h0030, 1'b0, 4'hF, '0, '0);
    push(K_LSR, c + 2, '0, 1'b0, 4'h0, '0, pat(14'h0030));
    push(K_IFG, c + 2, 14'h0020, 1'b0, 4'hF, '0, '0);
    push(K_IFR, c + 3, '0, 1'b0, 4'h0, '0, pat(14'h0020));
    push(K_LSG, c + 3, 14'h0030, 1'b0, 4'hF, '0, '0);
    push(K_LSR, c + 4, '0, 1'b0, 4'h0, '0, pat(14'h0030));
    repeat (4) step();
    if_req = 1'b0; ls_req = 1'b0;
    step(); step();
    @(negedge clk) chk("idle_cmd_zero", mem_cmd(), '0);

    // Single fetch with ready high.
    do_reset();
    c = cyc;
    if_req = 1'b1; if_addr = 14'h0010; mem_ready = 1'b1;
    push(K_IFG, c,     14'h0010, 1'b0, 4'hF, '0, '0);
    push(K_IFR, c + 1, '0, 1'b0, 4'h0, '0, pat(14'h0010));
    @(negedge clk) chk("if_gnt_same_cycle", {127'd0, if_gnt}, 128'd1);
    step();
    if_req = 1'b0;
    step(); step();

    // Stalled LS write stays on the port; IF must not preempt it.
    do_reset();
    c = cyc;
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 14'h1000; ls_wdata = 32'h00010000; ls_ben = 4'b0001;
    mem_ready = 1'b0;
    wr_exp = {75'd0, 1'b0, 1'b1, 1'b0, 4'b0001, 14'h1000, 32'h00010000};
    push(K_LSG, c + 3, 14'h1000, 1'b1, 4'b0001, 32'h00010000, '0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin if_req = 1'b1; if_addr = 14'h0044; end
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk) chk("wr_cmd_stable", mem_cmd(), wr_exp);
      step();
    end
    ls_req = 1'b0; ls_wen = 1'b0;
    push(K_IFG, c + 4, 14'h0044, 1'b0, 4'hF, '0, '0);
    push(K_IFR, c + 5, '0, 1'b0, 4'h0, '0, pat(14'h0044));
    step();
    if_req = 1'b0;
    step(); step();

    // Fence arriving while an LS read is completing its stalled issue.
    do_reset();
    c = cyc;
    ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 14'h0055; ls_ben = 4'hF; ls_wdata = '0;
    mem_ready = 1'b0;
    step();
    fence_req = 1'b1; mem_ready = 1'b1; if_req = 1'b1; if_addr = 14'h0066;
    push(K_LSG,  c + 1, 14'h0055, 1'b0, 4'hF, '0, '0);
    push(K_LSR,  c + 2, '0, 1'b0, 4'h0, '0, pat(14'h0055));
    push(K_DONE, c + 3, '0, 1'b0, 4'h0, '0, '0);
    push(K_IFG,  c + 4, 14'h0066, 1'b0, 4'hF, '0, '0);
    push(K_IFR,  c + 5, '0, 1'b0, 4'h0, '0, pat(14'h0066));
    step();
    ls_req = 1'b0;
    @(negedge clk) chk("drain_no_cmd", mem_cmd(), '0);
    step();
    @(negedge clk) chk("fence_wait_cmd", {125'd0, mem_fence_i, mem_ren, mem_wen}, 128'h4);
    step();
    fence_req = 1'b0;
    step();
    if_req = 1'b0;
    step(); step();

    // Reset while waiting on the fence: no done, IF wins the first tie afterwards.
    do_reset();
    c = cyc;
    fence_req = 1'b1; mem_ready = 1'b0;
    step(); step();
    @(negedge clk) chk("fence_i_held", {127'd0, mem_fence_i}, 128'd1);
    step();
    rst = 1'b1;
    if_req = 1'b1; if_addr = 14'h0070;
    ls_req = 1'b1; ls_addr = 14'h0071; ls_wen = 1'b0; ls_ben = 4'hF; ls_wdata = '0;
    @(negedge clk) chk("reset_mid_fence", all_outs(), '0);
    step();
    rst = 1'b0; fence_req = 1'b0; mem_ready = 1'b1;
    push(K_IFG, c + 4, 14'h0070, 1'b0, 4'hF, '0, '0);
    push(K_IFR, c + 5, '0, 1'b0, 4'h0, '0, pat(14'h0070));
    push(K_LSG, c + 5, 14'h0071, 1'b0, 4'hF, '0, '0);
    push(K_LSR, c + 6, '0, 1'b0, 4'h0, '0, pat(14'h0071));
    @(negedge clk) chk("fence_i_after_reset", {127'd0, mem_fence_i}, 128'd0);
    step(); step();
    if_req = 1'b0; ls_req = 1'b0;
    step(); step();

    @(negedge clk) chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 The block SHALL have parameter AW, default 14, meaning word-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 Port: i_clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: i_rst  input  1  reset, synchronous, active-high.
REQ-005 Port: i_if_req  input  1  instruction-fetch read request, held until granted.
REQ-006 Port: i_if_addr  input  AW  fetch word address.
REQ-007 Port: o_if_gnt  output  1  one-cycle pulse, fetch command accepted by memory.
REQ-008 Port: o_if_rvalid / o_if_rdata  output  1 / DW  fetch read data valid and data.
REQ-009 Port: i_ls_req, i_ls_wen, i_ls_ben[3:0], i_ls_addr[AW-1:0], i_ls_wdata[DW-1:0]  input  load/store request, held until granted.
REQ-010 Port: o_ls_gnt  output  1  one-cycle pulse, load/store command accepted.
REQ-011 Port: o_ls_rvalid / o_ls_rdata  output  1 / DW  load read data valid and data.
REQ-012 Port: i_fence_req  input  1  fence.i request, level, held until o_fence_done.
REQ-013 Port: o_fence_done  output  1  one-cycle pulse, fence complete.
REQ-014 Port: o_mem_ren, o_mem_wen, o_mem_ben[3:0], o_mem_addr[AW-1:0], o_mem_wdata[DW-1:0], o_mem_fence_i  output  single shared main-memory command port.
REQ-015 Port: i_mem_rdata  input  DW; i_mem_ready  input  1  memory accepts the command present this cycle.

Function
REQ-016 States SHALL be IDLE, ISSUE, FENCE_DRAIN, FENCE_WAIT.
REQ-017 Only one command (read, write or fence) SHALL be driven on the memory port in any cycle; o_mem_ren and o_mem_wen SHALL never both be 1.
REQ-018 In IDLE/ISSUE, with a pending fence absent, arbitration SHALL be round-robin: when both requesters are pending, the one not granted last wins; register last_gnt resets to LS, so IF wins the first tie.
REQ-019 The winner's command SHALL be driven combinationally on o_mem_* and held unchanged until i_mem_ready=1; the grant pulse (o_if_gnt / o_ls_gnt) SHALL assert in that same cycle.
REQ-020 The arbitration decision SHALL lock once a command is driven with i_mem_ready=0; the other requester SHALL not preempt it.
REQ-021 For a granted read, the matching o_*_rvalid SHALL pulse exactly one cycle after the grant, with o_*_rdata = i_mem_rdata in that cycle; a granted write produces no rvalid.
REQ-022 Back-to-back grants SHALL be allowed every cycle, giving a throughput of 1 command/cycle when i_mem_ready=1.
REQ-023 A 1-bit tag register SHALL route returning read data to the correct requester; rdata to the non-owning requester SHALL be 0.
REQ-024 When i_fence_req=1 in IDLE/ISSUE, no new grant SHALL be issued and the block SHALL enter FENCE_DRAIN; a command already driven but not yet accepted SHALL be completed first.
REQ-025 FENCE_DRAIN SHALL last until no read return is outstanding (at least the rvalid cycle of the last read), then move to FENCE_WAIT.
REQ-026 FENCE_WAIT SHALL drive o_mem_fence_i=1 with ren=wen=0 until i_mem_ready=1; in that cycle o_fence_done SHALL pulse and the state SHALL return to IDLE.
REQ-027 Fence SHALL have priority over both requesters; last_gnt is unchanged by a fence.
REQ-028 When there is no request, o_mem_ren, o_mem_wen and o_mem_fence_i SHALL be 0; o_mem_addr, o_mem_wdata and o_mem_ben are don't-care but SHALL be driven as 0.

Reset
REQ-029 While i_rst=1, all outputs SHALL be 0, state SHALL be IDLE, last_gnt SHALL be LS, the outstanding-read flag SHALL be cleared, and no grant, rvalid or done SHALL be pulsed.
REQ-030 Reset mid-operation SHALL abandon any pending command or fence without a completion pulse; requesters re-issue after reset.

Verification
REQ-031 With ready=1, IF read of addr 0x0010 -> o_if_gnt in the same cycle, o_mem_ren=1, addr=0x0010; next cycle o_if_rvalid=1 with rdata = memory word.
REQ-032 IF and LS both requesting continuously, ready=1 -> grants alternate IF, LS, IF, LS starting with IF after reset.
REQ-033 LS write addr 0x1000, wdata 0x00010000, ben=4'b0001, ready held 0 for 3 cycles -> command stable for 4 cycles, o_ls_gnt only in the 4th cycle, IF not granted meanwhile.
REQ-034 Fence asserted in the cycle of an LS read grant -> rvalid next cycle, then o_mem_fence_i=1; ready=1 -> o_fence_done pulse; no grants between the fence request and o_fence_done.
REQ-035 Reset asserted while in FENCE_WAIT with ready=0 -> next cycle all outputs 0, no o_fence_done, IF wins the first subsequent tie.
